jfpjc_stream_framer: RTL and testbench

- Consumer end of the bit packer's 32-bit word stream. Turns packed entropy-coded words into a byte-serial, byte-stuffed JPEG file stream.
- Per frame it emits, in order:
  - the fixed JFIF/DQT/DHT/SOF/SOS header, read from an external header ROM;
  - the stuffed scan data;
  - the EOI marker FF D9.
- Sits between the jfpjc bit packer and the downstream byte sink (SPI/UART/host FIFO). Replaces the stuffing and header prepend currently done in simulation.

---
 rtl/jfpjc_stream_framer.sv | 249 ++++++++++++++++++++++++
 tb/tb_jfpjc_stream_framer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jfpjc_stream_framer.sv
// jfpjc_stream_framer: turns the bit packer's 32-bit word stream into a
// byte-serial JPEG file stream. For each frame it emits the header from an
// external ROM, then the byte-stuffed scan data, then the EOI marker FF D9.
//
// Output handshake: out_data/out_valid come from a single holding register.
// A byte transfers on a posedge where out_valid && out_ready. Once out_valid
// is high, out_data is held stable and out_valid stays high until that
// transfer happens; only reset clears it otherwise. A new byte is loaded only
// when the holding register is empty or being emptied this cycle (slot_free).
// The input side has no backpressure: words arriving at a full FIFO are
// dropped and flagged in overflow.
module jfpjc_stream_framer #(
  parameter int HEADER_SIZE       = 328,
  parameter int HEADER_ADDR_WIDTH = 9,
  parameter int FIFO_DEPTH_LOG2   = 3
) (
  input  logic                         clock,
  input  logic                         nreset,
  input  logic                         frame_start,
  input  logic                         frame_end,
  input  logic [31:0]                  data_in,
  input  logic                         data_in_valid,
  output logic [HEADER_ADDR_WIDTH-1:0] header_addr,
  input  logic [7:0]                   header_data,
  output logic [7:0]                   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overflow,
  output logic [15:0]                  byte_count
);

  localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [HEADER_ADDR_WIDTH-1:0] LAST_ADDR = HEADER_ADDR_WIDTH'(HEADER_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_STUFF,
    S_EOI_FF,
    S_EOI_D9
  } state_t;

  state_t state, state_next;

  // Input word FIFO (one extra pointer bit distinguishes full from empty).
  logic [31:0]              fifo_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic                     fifo_empty, fifo_full, push, pop;
  logic [31:0]              fifo_head;

  // Word currently being serialised.
  logic [31:0] cur_word;
  logic [1:0]  byte_idx;
  logic        have_word;
  logic [7:0]  cur_byte;

  // Frame control.
  logic end_pending;
  logic rom_ok;       // header_data reflects the current header_addr
  logic d9_sent;      // D9 is sitting in the output register

  // Combinational controls from the FSM.
  logic       accept, slot_free;
  logic       load;
  logic [7:0] load_byte;
  logic       hdr_step, word_take, byte_step, eoi_done, clear_frame;

  assign accept     = out_valid && out_ready;
  assign slot_free  = !out_valid || out_ready;
  assign busy       = (state != S_IDLE);

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_DEPTH_LOG2] != rd_ptr[FIFO_DEPTH_LOG2]) &&
                      (wr_ptr[FIFO_DEPTH_LOG2-1:0] == rd_ptr[FIFO_DEPTH_LOG2-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];
  // A pop in the same cycle frees the slot, so a push while full is legal then.
  assign push       = data_in_valid && (!fifo_full || pop);

  // Pick the next byte of the current word, most significant first.
  always_comb begin
    cur_byte = cur_word[31:24];
    case (byte_idx)
      2'd0: cur_byte = cur_word[31:24];
      2'd1: cur_byte = cur_word[23:16];
      2'd2: cur_byte = cur_word[15:8];
      2'd3: cur_byte = cur_word[7:0];
      default: cur_byte = cur_word[31:24];
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state and per-cycle datapath controls.
  always_comb begin
    state_next  = state;
    load        = 1'b0;
    load_byte   = 8'h00;
    pop         = 1'b0;
    hdr_step    = 1'b0;
    word_take   = 1'b0;
    byte_step   = 1'b0;
    eoi_done    = 1'b0;
    clear_frame = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_start) begin
          clear_frame = 1'b1;
          state_next  = S_HEADER;
        end
      end
      S_HEADER: begin
        // The last header byte hands over to DATA as it is loaded; DATA can
        // only load its first byte once that header byte has been accepted.
        if (rom_ok && slot_free) begin
          load      = 1'b1;
          load_byte = header_data;
          hdr_step  = 1'b1;
          if (header_addr == LAST_ADDR) state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (slot_free) begin
          if (have_word) begin
            load      = 1'b1;
            load_byte = cur_byte;
            byte_step = 1'b1;
            if (cur_byte == 8'hFF) state_next = S_STUFF;
          end else if (!fifo_empty) begin
            // Pop and emit the first byte in the same cycle to keep 1 byte/cycle.
            pop       = 1'b1;
            word_take = 1'b1;
            load      = 1'b1;
            load_byte = fifo_head[31:24];
            if (fifo_head[31:24] == 8'hFF) state_next = S_STUFF;
          end else if (end_pending) begin
            state_next = S_EOI_FF;
          end
        end
      end
      S_STUFF: begin
        if (slot_free) begin
          load       = 1'b1;
          load_byte  = 8'h00;
          state_next = S_DATA;
        end
      end
      S_EOI_FF: begin
        if (slot_free) begin
          load       = 1'b1;
          load_byte  = 8'hFF;
          state_next = S_EOI_D9;
        end
      end
      S_EOI_D9: begin
        if (!d9_sent) begin
          if (slot_free) begin
            load      = 1'b1;
            load_byte = 8'hD9;
          end
        end else if (accept) begin
          eoi_done   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= data_in;
  end

  // FIFO pointers.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Output holding register and frame bookkeeping.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      out_valid   <= 1'b0;
      out_data    <= 8'h00;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      byte_count  <= 16'h0000;
      header_addr <= '0;
      rom_ok      <= 1'b0;
      end_pending <= 1'b0;
      d9_sent     <= 1'b0;
      cur_word    <= 32'h0;
      byte_idx    <= 2'd0;
      have_word   <= 1'b0;
    end else begin
      frame_done <= eoi_done;

      if (load) begin
        out_valid <= 1'b1;
        out_data  <= load_byte;
      end else if (accept) begin
        out_valid <= 1'b0;
      end

      if (clear_frame)                          byte_count <= 16'h0000;
      else if (accept && byte_count != 16'hFFFF) byte_count <= byte_count + 16'd1;

      if (clear_frame)                             overflow <= 1'b0;
      else if (data_in_valid && fifo_full && !pop) overflow <= 1'b1;

      if (clear_frame || eoi_done)               end_pending <= 1'b0;
      else if (frame_end && state != S_IDLE)     end_pending <= 1'b1;

      // Changing the address invalidates header_data for one cycle.
      if (clear_frame)                           header_addr <= '0;
      else if (hdr_step && header_addr != LAST_ADDR)
        header_addr <= header_addr + HEADER_ADDR_WIDTH'(1);
      rom_ok <= !(clear_frame || hdr_step);

      if (state == S_EOI_D9 && load)             d9_sent <= 1'b1;
      else if (clear_frame || eoi_done)          d9_sent <= 1'b0;

      if (clear_frame) begin
        have_word <= 1'b0;
        byte_idx  <= 2'd0;
      end else if (word_take) begin
        cur_word  <= fifo_head;
        byte_idx  <= 2'd1;
        have_word <= 1'b1;
      end else if (byte_step) begin
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) have_word <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jfpjc_stream_framer.sv
// Directed bench for jfpjc_stream_framer: header ROM model, scoreboard of
// expected output bytes, and a cycle-driven monitor that checks every
// accepted byte and output stability under backpressure.
module tb_jfpjc_stream_framer;

  localparam int HS    = 328;
  localparam int AW    = 9;
  localparam int FL    = 3;
  localparam int DEPTH = 1 << FL;

  logic          clock = 1'b0;
  logic          nreset = 1'b0;
  logic          frame_start = 1'b0;
  logic          frame_end = 1'b0;
  logic [31:0]   data_in = 32'h0;
  logic          data_in_valid = 1'b0;
  logic [AW-1:0] header_addr;
  logic [7:0]    header_data = 8'h00;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;
  logic          frame_done;
  logic          overflow;
  logic [15:0]   byte_count;

  logic [7:0] exp_q[$];
  int tests_run  = 0;
  int fail_cnt   = 0;
  int done_cnt   = 0;
  int acc_total  = 0;
  int frame_base = 0;
  int cyc        = 0;
  int t_first    = -1;
  int t_last     = -1;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;

  jfpjc_stream_framer #(
    .HEADER_SIZE(HS), .HEADER_ADDR_WIDTH(AW), .FIFO_DEPTH_LOG2(FL)
  ) dut (
    .clock(clock), .nreset(nreset), .frame_start(frame_start), .frame_end(frame_end),
    .data_in(data_in), .data_in_valid(data_in_valid), .header_addr(header_addr),
    .header_data(header_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .frame_done(frame_done),
    .overflow(overflow), .byte_count(byte_count)
  );

  // Clock.
  always #5 clock = ~clock;

  function automatic logic [7:0] rom_byte(input int a);
    return 8'((a * 37 + 11) ^ (a >> 2));
  endfunction

  // Header ROM model: synchronous read.
  always @(posedge clock) header_data <= rom_byte(int'(header_addr));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sampled at negedge: values seen here transfer at the following posedge.
  task automatic monitor();
    int idx;
    if (nreset) begin
      if (stall_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(stall_data));
      end
      if (frame_done) done_cnt++;
      if (out_valid && out_ready) begin
        idx = acc_total - frame_base;
        if (idx == HS)      t_first = cyc;
        if (idx == HS + 31) t_last  = cyc;
        if (exp_q.size() == 0) check($sformatf("extra_byte_%0d", idx), 32'(exp_q.size()), 32'd1);
        else                   check($sformatf("byte_%0d", idx), 32'(out_data), 32'(exp_q.pop_front()));
        acc_total++;
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end else begin
      stall_prev = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clock);
    monitor();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic start_frame();
    for (int i = 0; i < HS; i++) exp_q.push_back(rom_byte(i));
    frame_base = acc_total;
    t_first = -1;
    t_last  = -1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic exp_word(input logic [31:0] w);
    logic [7:0] b;
    for (int k = 3; k >= 0; k--) begin
      b = w[8*k +: 8];
      exp_q.push_back(b);
      if (b == 8'hFF) exp_q.push_back(8'h00);
    end
  endtask

  task automatic push_word(input logic [31:0] w, input bit keep);
    data_in = w;
    data_in_valid = 1'b1;
    if (keep) exp_word(w);
    tick();
    data_in_valid = 1'b0;
  endtask

  task automatic end_frame();
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hD9);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  task automatic wait_bytes(input string tag, input int n);
    int k = 0;
    while ((acc_total - frame_base) < n && k < 3000) begin
      tick();
      k++;
    end
    check({tag, "_reached"}, 32'((acc_total - frame_base) >= n), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int exp_bytes, input bit rnd);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < 4000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    out_ready = 1'b1;
    check({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    repeat (3) tick();
    check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_byte_count"}, 32'(byte_count), 32'(exp_bytes));
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    // Reset state.
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_byte_count", 32'(byte_count), 32'd0);
    check("rst_header_addr", 32'(header_addr), 32'd0);
    repeat (2) tick();
    nreset = 1'b1;
    tick();

    // Header only, plus first-byte latency.
    start_frame();
    check("hdr_busy", 32'(busy), 32'd1);
    check("hdr_addr0", 32'(header_addr), 32'd0);
    repeat (2) tick();
    check("hdr_first_valid", 32'(out_valid), 32'd1);
    end_frame();
    wait_done("hdr_only", HS + 2, 1'b0);

    // Single word with two 0xFF bytes: 12 FF 00 34 FF 00.
    start_frame();
    push_word(32'h12FF34FF, 1'b1);
    end_frame();
    wait_done("one_word", HS + 6 + 2, 1'b0);

    // All-FF words at full rate.
    start_frame();
    for (int i = 0; i < 4; i++) push_word(32'hFFFFFFFF, 1'b1);
    end_frame();
    wait_done("all_ff", HS + 32 + 2, 1'b0);
    check("all_ff_rate", 32'(t_last - t_first), 32'd31);

    // Random backpressure.
    start_frame();
    for (int i = 0; i < 3; i++) push_word(32'hA5A5A5A5, 1'b1);
    end_frame();
    wait_done("backpressure", HS + 12 + 2, 1'b1);

    // Overflow: sink stalled while 10 words arrive; only the first 8 fit.
    start_frame();
    wait_bytes("ovf_hdr", HS - 1);
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++)
      push_word({8'(i), 8'hFF, 8'(i * 3), 8'h5A}, i < DEPTH);
    check("ovf_set", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    end_frame();
    wait_done("ovf", HS + DEPTH * 5 + 2, 1'b0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Next frame clears overflow and the byte count.
    start_frame();
    check("ovf_cleared", 32'(overflow), 32'd0);
    check("count_cleared", 32'(byte_count), 32'd0);
    check("addr_cleared", 32'(header_addr), 32'd0);
    end_frame();
    wait_done("after_ovf", HS + 2, 1'b0);

    // Reset in the middle of scan data.
    start_frame();
    push_word(32'h11223344, 1'b1);
    push_word(32'h55667788, 1'b1);
    push_word(32'h99AABBCC, 1'b1);
    push_word(32'hDDEEF001, 1'b1);
    wait_bytes("mid_data", HS + 4);
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    nreset = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_frame_done", 32'(frame_done), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_byte_count", 32'(byte_count), 32'd0);
    check("mid_rst_header_addr", 32'(header_addr), 32'd0);
    exp_q.delete();
    repeat (2) tick();
    nreset = 1'b1;
    tick();
    start_frame();
    end_frame();
    wait_done("post_reset", HS + 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
